// File: rtl/led7_scan_driver.sv
// led7_scan_driver: multi-digit seven-segment scan driver.
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared segment bus.
// Features: refresh prescaler, frame-boundary data update, leading-zero
// blanking and per-digit blinking.
module led7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              led_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         active_q, active_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [6:0]            led_q, led_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_done_q, frame_done_d;

    logic slot_end_s;
    logic wrap_s;

    // Slot end and frame wrap qualifiers, only meaningful while scanning.
    always_comb begin
        slot_end_s = enable && (presc_q == PRESC_LAST);
        wrap_s     = slot_end_s && (idx_q == IDX_LAST);
    end

    // Prescaler, digit index and blink timebase; all hold while disabled.
    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (enable) begin
            if (slot_end_s) begin
                presc_d = '0;
                if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
        if (wrap_s) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
    end

    // Double-buffered data: the active word only changes on a frame wrap,
    // so one frame never mixes two loads; a load on the wrap goes direct.
    always_comb begin
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (load && wrap_s) begin
            active_d        = data_in;
            pending_valid_d = 1'b0;
        end else if (load) begin
            pending_d       = data_in;
            pending_valid_d = 1'b1;
        end else if (wrap_s && pending_valid_q) begin
            active_d        = pending_q;
            pending_valid_d = 1'b0;
        end else begin
            pending_valid_d = pending_valid_q;
        end
    end

    // Output word for the digit currently indexed, with blanking applied.
    always_comb begin
        logic                  zero_acc;
        logic [NUM_DIGITS-1:0] upper_zero;
        logic [3:0]            nib;
        logic                  lz_hit;
        logic                  blink_hit;
        zero_acc  = 1'b1;
        upper_zero = '0;
        nib       = 4'h0;
        lz_hit    = 1'b0;
        blink_hit = 1'b0;
        sel_d     = '0;
        led_d     = 7'h00;
        // upper_zero[k]: nibbles k..NUM_DIGITS-1 are all zero
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_acc      = zero_acc & (active_q[4*k +: 4] == 4'h0);
            upper_zero[k] = zero_acc;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = active_q[4*k +: 4];
                lz_hit    = (k != 0) && blank_lz && upper_zero[k];
                blink_hit = blink_mask[k] && blink_phase_q;
                sel_d[k]  = enable;
            end else begin
                sel_d[k] = 1'b0;
            end
        end
        if (enable && !(lz_hit || blink_hit)) begin
            led_d = seg7(nib);
        end else begin
            led_d = 7'h00;
        end
        frame_done_d = wrap_s;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q         <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            blink_cnt_q     <= '0;
            blink_phase_q   <= 1'b0;
            led_q           <= 7'h00;
            sel_q           <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            presc_q         <= presc_d;
            idx_q           <= idx_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_phase_q   <= blink_phase_d;
            led_q           <= led_d;
            sel_q           <= sel_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign led_out    = led_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7_scan_driver.sv
// Scoreboard bench for led7_scan_driver (4 digits, PRESCALE=4, BLINK_FRAMES=2).
// Stimulus pushes {frame_done, digit_sel, led_out} per displayed cycle;
// a monitor pops and compares whenever a digit is selected.
module tb_led7_scan_driver;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic [6:0]  led_out;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int n_tests;
    int n_fail;
    logic [11:0] exp_q[$];

    led7_scan_driver #(
        .NUM_DIGITS  (4),
        .PRESCALE    (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .data_in   (data_in),
        .blank_lz  (blank_lz),
        .blink_mask(blink_mask),
        .led_out   (led_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_slot(input int d, input logic [6:0] led, input int n, input bit wrap);
        logic [3:0] sel;
        sel = 4'b0001 << d;
        for (int c = 0; c < n; c++) begin
            exp_q.push_back({(wrap && (c == n - 1)), sel, led});
        end
    endtask

    task automatic push_frame(input logic [6:0] l0, input logic [6:0] l1,
                              input logic [6:0] l2, input logic [6:0] l3);
        push_slot(0, l0, 4, 1'b0);
        push_slot(1, l1, 4, 1'b0);
        push_slot(2, l2, 4, 1'b0);
        push_slot(3, l3, 4, 1'b1);
    endtask

    task automatic load_pulse(input logic [15:0] d);
        load    = 1'b1;
        data_in = d;
        tick(1);
        load    = 1'b0;
    endtask

    // Monitor: compare every selected cycle against the scoreboard; dark cycles must be blank.
    always @(negedge clk) begin
        if (digit_sel != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none",
                         {frame_done, digit_sel, led_out});
            end else begin
                check("display", {frame_done, digit_sel, led_out}, exp_q.pop_front());
            end
        end else begin
            check("dark", {frame_done, digit_sel, led_out}, 12'h000);
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        data_in    = 16'h0000;
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        tick(2);
        check("reset_led", {5'b00000, led_out}, 12'h000);
        check("reset_sel", {8'h00, digit_sel}, 12'h000);
        check("reset_fd", {11'h000, frame_done}, 12'h000);
        rst = 1'b0;
        tick(2);

        // Frame 0: load 1234 goes to pending, active still zero
        enable = 1'b1;
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        load_pulse(16'h1234);
        tick(15);

        // Frame 1: 1234 displayed; load 0070 for the next frame
        push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
        tick(5);
        load_pulse(16'h0070);
        tick(10);

        // Frame 2: leading-zero blanking on 0070
        blank_lz = 1'b1;
        push_frame(7'h3F, 7'h07, 7'h00, 7'h00);
        tick(3);
        load_pulse(16'h0000);
        tick(12);

        // Frame 3: all zero, only digit 0 lit; two loads, last wins
        push_frame(7'h3F, 7'h00, 7'h00, 7'h00);
        tick(3);
        load_pulse(16'h1111);
        tick(4);
        load_pulse(16'h2222);
        tick(7);

        // Frame 4: 2222 shown; load ABCD on the wrap edge
        blink_mask = 4'b0001;
        push_frame(7'h5B, 7'h5B, 7'h5B, 7'h5B);
        tick(15);
        load_pulse(16'hABCD);

        // Frames 5..7: blink phase 0 then 1
        push_frame(7'h5E, 7'h39, 7'h7C, 7'h77);
        tick(16);
        push_frame(7'h00, 7'h39, 7'h7C, 7'h77);
        tick(16);
        push_frame(7'h00, 7'h39, 7'h7C, 7'h77);
        tick(16);

        // Frame 8: blink phase 0 again; enable drops mid digit 2
        push_frame(7'h5E, 7'h39, 7'h7C, 7'h77);
        tick(10);
        enable = 1'b0;
        tick(10);
        enable = 1'b1;
        tick(6);

        // Frame 9: partial, pending load, then async reset
        push_slot(0, 7'h5E, 4, 1'b0);
        push_slot(1, 7'h39, 2, 1'b0);
        tick(3);
        load_pulse(16'h5555);
        tick(2);
        #5;
        rst = 1'b1;
        #1;
        check("async_rst_led", {5'b00000, led_out}, 12'h000);
        check("async_rst_sel", {8'h00, digit_sel}, 12'h000);
        check("async_rst_fd", {11'h000, frame_done}, 12'h000);
        blank_lz   = 1'b0;
        blink_mask = 4'b0000;
        tick(2);

        // After reset: active and pending cleared, two frames of zeros
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F);
        rst = 1'b0;
        tick(32);

        enable = 1'b0;
        tick(3);
        check("scoreboard_drained", 12'(exp_q.size()), 12'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led7_scan_driver.md
Name: led7_scan_driver

Overview:
- Parametrised multi-digit seven-segment scan driver; successor to the single-digit binary-to-LED7 decoder.
- Time-multiplexes NUM_DIGITS hex nibbles onto one shared segment bus with a one-hot digit select.
- Adds a refresh prescaler, atomic frame-boundary data update, leading-zero blanking and per-digit blinking.
- Sits between the datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- PRESCALE, 1000, enabled clock cycles per digit slot; must be at least 1.
- BLINK_FRAMES, 256, complete scan frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scanning runs and display is driven; 0 = scan holds and display is dark.
- load  in  1  single-cycle strobe that captures data_in.
- data_in  in  4*NUM_DIGITS  hex nibbles; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- blank_lz  in  1  1 = blank leading zero digits.
- blink_mask  in  NUM_DIGITS  bit k = 1 makes digit k blink.
- led_out  out  7  segments {g,f,e,d,c,b,a}, active-high.
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset, asynchronous: led_out=0, digit_sel=0, frame_done=0.
- Reset also clears: prescaler=0, digit index idx=0, active register=0, pending register=0, pending_valid=0, blink frame counter=0, blink_phase=0.
- Reset mid-operation discards pending data.
- Prescaler, only while enable=1:
  - Counts 0..PRESCALE-1.
  - At PRESCALE-1 it returns to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - PRESCALE=1 advances idx on every enabled cycle.
- Frame wrap (idx goes NUM_DIGITS-1 to 0):
  - frame_done=1 for exactly that cycle; it is registered and asserts on the same edge idx becomes 0.
  - Blink counter increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Output timing:
  - led_out and digit_sel are registered from state held before the edge, so they lag idx by one cycle.
  - Each digit is shown for exactly PRESCALE consecutive cycles.
  - The first enabled edge after reset shows digit 0.
- Digit output: digit_sel = one-hot(idx). led_out = segment code of active nibble idx unless that digit is blanked.
- Blanked digit: led_out=0, digit_sel still asserted.
- Segment codes, hex:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Leading-zero blanking: digit k>0 is blanked when blank_lz=1 and active nibbles k..NUM_DIGITS-1 are all 0. Digit 0 is never blanked by this rule.
- Blink: digit k is blanked when blink_mask[k]=1 and blink_phase=1.
- Load:
  - When load=1, data_in is captured into pending and pending_valid is set.
  - At a frame-wrap edge with pending_valid=1, active takes pending and pending_valid clears.
  - If load coincides with a frame-wrap edge, data_in goes straight into active and pending_valid clears (newest data wins).
  - Consecutive loads inside one frame: the last one wins.
  - The display never shows a mix of two loads within one frame.
- enable=0:
  - Prescaler, idx and blink state hold.
  - led_out=0 and digit_sel=0 from the next edge; frame_done=0.
  - load is still accepted.
  - Re-enable resumes from the held idx and prescaler.
- blank_lz and blink_mask are sampled combinationally into the output register every cycle; changes take effect on the next edge.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLINK_FRAMES=2):
- Reset, enable=1, load 0x1234 for one cycle, blank_lz=0:
  - First frame shows 3F on every digit, digit_sel 0001, 0010, 0100, 1000, each held 4 cycles.
  - frame_done pulses once after 16 enabled cycles.
  - Second frame shows 66, 4F, 5B, 06.
- Active 0x0070, blank_lz=1:
  - digit0=3F, digit1=07, digit2=00, digit3=00; digit_sel still cycles through all four.
  - Active 0x0000 shows digit0=3F and the rest 00.
- Load 0x1111 mid-frame, then 0x2222 in the same frame: the next frame shows only 5B; 06 never appears.
- load asserted on the frame_done edge with 0xABCD: the frame that starts on that edge shows 5E, 39, 7C, 77 (digit0..3).
- blink_mask=0001:
  - digit0 is shown for frames 0-1, 00 for frames 2-3, shown for frames 4-5.
  - The other digits are unaffected.
- enable dropped mid-slot on digit 2 for 10 cycles:
  - Outputs go 0 on the next edge.
  - On re-enable, digit 2 finishes its remaining slot cycles.
  - Assert rst mid-frame: all outputs 0 asynchronously, and the next frame displays 3F on all digits.
